pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have a parameter STAGES, default 4, giving the number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES, with chunk width CW = WIDTH/STAGES.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk (in, 1, rising-edge clock) and rst_n (in, 1, asynchronous active-low reset).
REQ-004 Port a  in  WIDTH  operand A.
REQ-005 Port b  in  WIDTH  operand B.
REQ-006 Port c_in  in  1  carry into bit 0.
REQ-007 Port in_valid  in  1  operands valid.
REQ-008 Port in_ready  out  1  block accepts operands this cycle.
REQ-009 Port sum  out  WIDTH  result.
REQ-010 Port c_out  out  1  carry out of the MSB.
REQ-011 Port ovf  out  1  two's-complement signed overflow.
REQ-012 Port out_valid  out  1  result valid.
REQ-013 Port out_ready  in  1  downstream accepts result.

Function
REQ-014 Stage k (k = 0..STAGES-1) SHALL add chunk k of a and b, bits [k*CW +: CW], plus the carry registered by stage k-1; stage 0 SHALL use c_in.
REQ-015 Unconsumed upper operand chunks SHALL be delayed with the carry (input skew), and completed lower sum chunks SHALL be delayed to align (output deskew).
REQ-016 advance = out_ready OR NOT out_valid; all stage registers SHALL load only when advance = 1, and hold otherwise.
REQ-017 in_ready SHALL equal advance combinationally; a transfer occurs when in_valid AND in_ready.
REQ-018 Each stage SHALL carry a valid bit; stage 0 valid SHALL load in_valid on advance; out_valid SHALL be the last-stage valid bit.
REQ-019 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid = 1, provided there is no stall.
REQ-020 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-021 sum and c_out SHALL equal (a + b + c_in) mod 2^(WIDTH+1), split into sum = low WIDTH bits and c_out = bit WIDTH.
REQ-022 ovf SHALL be 1 when a[MSB] = b_eff[MSB] and sum[MSB] != a[MSB], where b_eff is the b actually added.
REQ-023 While out_valid = 1 and out_ready = 0, sum, c_out and ovf SHALL remain stable and no result SHALL be lost or duplicated.
REQ-024 Bubbles (in_valid = 0 on an accepting edge) SHALL propagate as out_valid = 0 and SHALL NOT corrupt adjacent results.
REQ-025 With STAGES = 1 the block SHALL behave as a single registered adder with latency 1.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear all valid bits, sum, c_out, ovf and carry registers to 0, regardless of the clock.
REQ-027 Data in flight when reset is asserted mid-operation SHALL be discarded; no out_valid pulse SHALL follow reset release without a new transfer.
REQ-028 After reset, in_ready SHALL be 1, because out_valid = 0.

Configuration
REQ-029 With macro PIPELINED_ADDER_SUBTRACT_EN defined, an input port sub (1 bit, sampled with a) SHALL be present; sub = 1 SHALL compute a + ~b + 1 with c_in ignored, c_out = 1 meaning no borrow, and ovf evaluated on ~b.
REQ-030 Without PIPELINED_ADDER_SUBTRACT_EN, the port sub SHALL be absent and the block SHALL only add.

Structure
REQ-031 Package adder_pkg SHALL hold the default WIDTH and STAGES constants and a function computing CW.
REQ-032 Sub-module adder_slice (CW-bit combinational a + b + cin, giving sum and cout) SHALL be instantiated once per stage in a generate loop.

Verification (WIDTH = 16, STAGES = 4)
REQ-033 a = 0x1234, b = 0x1111, c_in = 0, out_ready = 1 SHALL give sum = 0x2345, c_out = 0, ovf = 0, with out_valid exactly 4 cycles after acceptance.
REQ-034 a = 0xFFFF, b = 0x0001, c_in = 0 (carry ripples through all stages) SHALL give sum = 0x0000, c_out = 1, ovf = 0.
REQ-035 a = 0x7FFF, b = 0x0001 SHALL give sum = 0x8000, ovf = 1; a = 0x8000, b = 0x8000 SHALL give sum = 0x0000, c_out = 1, ovf = 1.
REQ-036 Back-to-back random operands, with out_ready held 0 for 3 cycles mid-stream, SHALL give in_ready = 0 during the stall, outputs held stable, and all results in order with none lost; this SHALL be checked against a reference model over 1000 transactions.
REQ-037 Asserting rst_n low 2 cycles after accepting a = 0x00FF, b = 0x0001 SHALL give out_valid = 0 immediately and no result after release.
REQ-038 With PIPELINED_ADDER_SUBTRACT_EN defined, sub = 1, a = 0x0005, b = 0x0007 SHALL give sum = 0xFFFE, c_out = 0, ovf = 0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder.
// Default WIDTH/STAGES and chunk-width helper.
package adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_w(input int w, input int s);
    return w / s;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// CW-bit combinational adder slice.
// Ports: a, b, cin in; sum, cout out.
module adder_slice #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b}
                     + {{CW{1'b0}}, cin};
endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder, one CW-bit chunk per stage, valid/ready flow.
// Ports: clk, rst_n, a, b, c_in, [sub], in_valid/in_ready,
//   sum, c_out, ovf, out_valid/out_ready.
// Option: PIPELINED_ADDER_SUBTRACT_EN adds port sub (a - b).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef PIPELINED_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW  = chunk_w(WIDTH, STAGES);
  localparam int MSB = WIDTH - 1;
  localparam int LS  = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] b_in;
  logic             c0;

`ifdef PIPELINED_ADDER_SUBTRACT_EN
  assign b_in = sub ? ~b : b;
  assign c0   = sub ? 1'b1 : c_in;
`else
  assign b_in = b;
  assign c0   = c_in;
`endif

  // Per-stage registers: skewed operands, partial sum, carry, valid.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic             v_q [STAGES];
  logic             v_d [STAGES];

  // What enters stage k: the ports for k = 0, else stage k-1.
  logic [WIDTH-1:0] op_a [STAGES];
  logic [WIDTH-1:0] op_b [STAGES];
  logic [WIDTH-1:0] op_s [STAGES];
  logic             op_c [STAGES];
  logic             op_v [STAGES];
  logic [CW-1:0]    ch_s [STAGES];
  logic             ch_c [STAGES];

  assign advance  = out_ready | ~v_q[LS];
  assign in_ready = advance;

  always_comb begin
    op_a[0] = a;
    op_b[0] = b_in;
    op_s[0] = '0;
    op_c[0] = c0;
    op_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      op_a[k] = a_q[k-1];
      op_b[k] = b_q[k-1];
      op_s[k] = s_q[k-1];
      op_c[k] = c_q[k-1];
      op_v[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.CW(CW)) u_slice (
      .a    (op_a[k][k*CW +: CW]),
      .b    (op_b[k][k*CW +: CW]),
      .cin  (op_c[k]),
      .sum  (ch_s[k]),
      .cout (ch_c[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
      v_d[k] = v_q[k];
      if (advance) begin
        a_d[k] = op_a[k];
        b_d[k] = op_b[k];
        s_d[k] = op_s[k];
        s_d[k][k*CW +: CW] = ch_s[k];
        c_d[k] = ch_c[k];
        v_d[k] = op_v[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
    end
  end

  // Last stage carries the full operands, so overflow uses b_eff.
  assign sum       = s_q[LS];
  assign c_out     = c_q[LS];
  assign out_valid = v_q[LS];
  assign ovf = (a_q[LS][MSB] == b_q[LS][MSB])
             & (s_q[LS][MSB] != a_q[LS][MSB]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH 16, STAGES 4).
// Random + directed stimulus against an arithmetic reference model.
module tb_pipelined_adder;
  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           cyc;
    bit           lat;
    bit           lit;
    logic [W-1:0] ls;
    logic         lc;
    logic         lo;
  } exp_t;

  logic         clk = 0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         c_in, sub;
  logic         in_valid, in_ready;
  logic [W-1:0] sum;
  logic         c_out, ovf, out_valid, out_ready;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   stall_cnt = 0;
  bit   rnd_bp  = 0;
  bit   lat_chk = 0;
  bit   cur_lit = 0;
  logic [W-1:0] cur_ls;
  logic cur_lc, cur_lo;
  exp_t sb[$];

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef PIPELINED_ADDER_SUBTRACT_EN
    .sub       (sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endfunction

  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                 logic ci, logic sb_);
    exp_t m;
    logic [W-1:0] be;
    logic [W:0]   r;
    be  = sb_ ? ~y : y;
    r   = {1'b0, x} + {1'b0, be} + (sb_ ? 17'd1 : {16'd0, ci});
    m.s = r[W-1:0];
    m.c = r[W];
    m.o = (x[W-1] == be[W-1]) && (r[W-1] != x[W-1]);
    m.cyc = 0; m.lat = 0; m.lit = 0;
    m.ls = '0; m.lc = 0; m.lo = 0;
    return m;
  endfunction

  function automatic logic sub_eff();
`ifdef PIPELINED_ADDER_SUBTRACT_EN
    return sub;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor / scoreboard
  initial begin : mon
    bit held = 0;
    logic [W-1:0] hs;
    logic hc, ho;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        held = 0;
        continue;
      end
      if (held) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_sum", 32'(sum), 32'(hs));
        chk("stall_cout", 32'({c_out, ovf}), 32'({hc, ho}));
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        held = 1; hs = sum; hc = c_out; ho = ovf;
      end else begin
        held = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("c_out", 32'(c_out), 32'(e.c));
          chk("ovf", 32'(ovf), 32'(e.o));
          if (e.lit) begin
            chk("lit_sum", 32'(sum), 32'(e.ls));
            chk("lit_c_out", 32'(c_out), 32'(e.lc));
            chk("lit_ovf", 32'(ovf), 32'(e.lo));
          end
          if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(S));
        end
      end
      if (in_valid && in_ready) begin
        e = model(a, b, c_in, sub_eff());
        e.cyc = cyc; e.lat = lat_chk;
        e.lit = cur_lit; e.ls = cur_ls; e.lc = cur_lc; e.lo = cur_lo;
        sb.push_back(e);
      end
    end
  end

  // Downstream backpressure
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        out_ready = 0;
        stall_cnt--;
      end else if (rnd_bp) begin
        out_ready = ($urandom_range(0, 9) != 0);
      end else begin
        out_ready = 1;
      end
    end
  end

  task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic ci,
                      logic sbt, bit lit, logic [W-1:0] ls,
                      logic lc, logic lo);
    int t;
    @(posedge clk);
    #1;
    a = x; b = y; c_in = ci; sub = sbt;
    cur_lit = lit; cur_ls = ls; cur_lc = lc; cur_lo = lo;
    in_valid = 1;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 0;
      cur_lit = 0;
    end
  endtask

  initial begin
    int t;
    rst_n = 0; in_valid = 0; a = 0; b = 0; c_in = 0; sub = 0;
    cur_ls = 0; cur_lc = 0; cur_lo = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", 32'({c_out, ovf}), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed corner cases with latency checks
    lat_chk = 1;
    send(16'h1234, 16'h1111, 0, 0, 1, 16'h2345, 0, 0);
    send(16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000, 1, 0);
    send(16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 0, 1);
    send(16'h8000, 16'h8000, 0, 0, 1, 16'h0000, 1, 1);
    idle(1);
    send(16'h0F0F, 16'h00F1, 1, 0, 0, 0, 0, 0);
`ifdef PIPELINED_ADDER_SUBTRACT_EN
    send(16'h0005, 16'h0007, 1, 1, 1, 16'hFFFE, 0, 0);
    sub = 0;
`endif
    idle(S + 2);
    lat_chk = 0;

    // Reset mid-flight discards the transaction
    send(16'h00FF, 16'h0001, 0, 0, 0, 0, 0, 0);
    idle(1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (S + 4) begin
      @(negedge clk);
      chk("post_rst_no_out", 32'(out_valid), 32'd0);
    end

    // Random stream with bubbles, backpressure and fixed stalls
    rnd_bp = 1;
    for (int i = 0; i < 1000; i++) begin
      logic sbt;
`ifdef PIPELINED_ADDER_SUBTRACT_EN
      sbt = 1'($urandom_range(0, 1));
`else
      sbt = 0;
`endif
      if (i == 300 || i == 700) stall_cnt = 3;
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
           sbt, 0, 0, 0, 0);
      if ($urandom_range(0, 6) == 0) idle(1);
    end
    idle(1);
    rnd_bp = 0;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
